// File: rtl/dcim_pkg.sv
// rtl/dcim_pkg.sv - shared widths, state encoding and types for the DCIM result collector
package dcim_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int MULT_WIDTH = DATA_WIDTH * 2;
  localparam int ADDR_COUNT = 32;
  localparam int ADDR_WIDTH = $clog2(ADDR_COUNT);
  localparam int ACC_WIDTH  = MULT_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} collector_state_t;
  typedef logic [MULT_WIDTH-1:0] product_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/dcim_result_collector_if.sv
// rtl/dcim_result_collector_if.sv - capture stream from the DCIM array and drain stream to the consumer
interface dcim_result_collector_if;
  import dcim_pkg::*;

  logic     in_valid;
  product_t in_data;
  logic     rd_valid;
  logic     rd_ready;
  product_t rd_data;
  addr_t    rd_addr;

  modport master (input in_valid, input in_data, input rd_ready,
                  output rd_valid, output rd_data, output rd_addr);
  modport slave  (output in_valid, output in_data, output rd_ready,
                  input rd_valid, input rd_data, input rd_addr);
endinterface

// File: rtl/dcim_result_buffer.sv
// rtl/dcim_result_buffer.sv - one-write/one-read frame store with a registered read port
module dcim_result_buffer
  import dcim_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  addr_t    wr_addr,
  input  product_t wr_data,
  input  logic     rd_en,
  input  addr_t    rd_addr,
  output product_t rd_data
);
  product_t mem [ADDR_COUNT];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when rd_en is low, which gives the drain its stall behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/dcim_result_collector.sv
// rtl/dcim_result_collector.sv - captures a 32-entry DCIM frame and drains it over a valid/ready stream
// Optional frame accumulator enabled by defining DCIM_COLLECTOR_ACCUM_EN.
module dcim_result_collector
  import dcim_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  dcim_result_collector_if.master     bus,
  output logic                        frame_done,
  output logic                        overflow,
  output logic [ACC_WIDTH-1:0]        acc_sum,
  output logic                        acc_valid
);
  localparam addr_t LAST_ADDR = addr_t'(ADDR_COUNT - 1);

  collector_state_t state, next_state;
  addr_t            wr_ptr, rd_ptr, wr_addr, rd_load_addr;
  logic             rd_valid_q, wr_en, last_wr, fire, rd_load, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (frame_start) next_state = CAPTURE;
    else begin
      case (state)
        CAPTURE: if (bus.in_valid && wr_ptr == LAST_ADDR) next_state = DRAIN;
        DRAIN:   if (rd_valid_q && bus.rd_ready && rd_ptr == LAST_ADDR) next_state = IDLE;
        default: next_state = state;
      endcase
    end
  end

  // frame_start overrides everything, including a transfer or capture in the same cycle.
  always_comb begin
    wr_en        = bus.in_valid && (frame_start || state == CAPTURE);
    wr_addr      = frame_start ? '0 : wr_ptr;
    last_wr      = !frame_start && state == CAPTURE && bus.in_valid && wr_ptr == LAST_ADDR;
    fire         = !frame_start && state == DRAIN && rd_valid_q && bus.rd_ready;
    rd_load      = last_wr || (fire && rd_ptr != LAST_ADDR);
    rd_load_addr = last_wr ? '0 : rd_ptr + 1'b1;
    drop         = !frame_start && bus.in_valid && state != CAPTURE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else if (frame_start) begin
      wr_ptr     <= bus.in_valid ? addr_t'(1) : '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_en)   wr_ptr     <= wr_ptr + 1'b1;
      if (last_wr) rd_valid_q <= 1'b1;
      if (drop)    overflow   <= 1'b1;
      if (fire) begin
        if (rd_ptr == LAST_ADDR) begin
          rd_ptr     <= '0;
          rd_valid_q <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  dcim_result_buffer u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.in_data),
    .rd_en   (rd_load),
    .rd_addr (rd_load_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_ptr;

`ifdef DCIM_COLLECTOR_ACCUM_EN
  logic [ACC_WIDTH-1:0] acc;

  // Running sum of the frame; published when the last product lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      acc_sum   <= '0;
      acc_valid <= 1'b0;
    end else if (frame_start) begin
      acc       <= bus.in_valid ? ACC_WIDTH'(bus.in_data) : '0;
      acc_sum   <= '0;
      acc_valid <= 1'b0;
    end else if (wr_en) begin
      acc <= acc + ACC_WIDTH'(bus.in_data);
      if (last_wr) begin
        acc_sum   <= acc + ACC_WIDTH'(bus.in_data);
        acc_valid <= 1'b1;
      end
    end
  end
`else
  assign acc_sum   = '0;
  assign acc_valid = 1'b0;
`endif
endmodule

// File: tb/tb_dcim_result_collector.sv
// tb/tb_dcim_result_collector.sv - self-checking bench with a frame/queue model of the collector
module tb_dcim_result_collector;
  import dcim_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic frame_done, overflow, acc_valid;
  logic [ACC_WIDTH-1:0] acc_sum;

  dcim_result_collector_if bus ();

  dcim_result_collector dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bus         (bus),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .acc_sum     (acc_sum),
    .acc_valid   (acc_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a frame is a list of captured products; a completed frame becomes the drain queue.
  bit                   m_capturing, m_done, m_ovf, m_acc_valid;
  product_t             m_frame[$];
  product_t             m_drain[$];
  logic [ACC_WIDTH-1:0] m_acc_sum, exp_acc;
  bit                   exp_accv, prev_valid, done_seen;
  int                   first_valid_cyc, done_cyc;
  int                   beat_addr[$];
  product_t             beat_data[$];

  always @(negedge clk) begin
    if (rst) begin
      m_capturing = 0; m_done = 0; m_ovf = 0; m_acc_valid = 0; m_acc_sum = '0;
      m_frame.delete(); m_drain.delete(); prev_valid = 0;
      check("reset_rd_valid", bus.rd_valid, 0);
      check("reset_rd_data", bus.rd_data, 0);
      check("reset_rd_addr", bus.rd_addr, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_overflow", overflow, 0);
      check("reset_acc", {acc_valid, acc_sum}, 0);
    end else begin
`ifdef DCIM_COLLECTOR_ACCUM_EN
      exp_acc = m_acc_sum; exp_accv = m_acc_valid;
`else
      exp_acc = '0; exp_accv = 0;
`endif
      check("rd_valid", bus.rd_valid, m_drain.size() > 0);
      if (m_drain.size() > 0) begin
        check("rd_data", bus.rd_data, m_drain[0]);
        check("rd_addr", bus.rd_addr, ADDR_COUNT - m_drain.size());
      end
      check("frame_done", frame_done, m_done);
      check("overflow", overflow, m_ovf);
      check("acc_sum", acc_sum, exp_acc);
      check("acc_valid", acc_valid, exp_accv);

      if (bus.rd_valid && !prev_valid) first_valid_cyc = cyc;
      prev_valid = bus.rd_valid;
      if (frame_done) begin done_seen = 1; done_cyc = cyc; end
      if (bus.rd_valid && bus.rd_ready && !frame_start) begin
        beat_addr.push_back(int'(bus.rd_addr));
        beat_data.push_back(bus.rd_data);
      end

      m_done = 0;
      if (frame_start) begin
        m_drain.delete(); m_frame.delete();
        m_capturing = 1; m_ovf = 0; m_acc_valid = 0; m_acc_sum = '0;
        if (bus.in_valid) m_frame.push_back(bus.in_data);
      end else begin
        if (m_drain.size() > 0 && bus.rd_ready) begin
          void'(m_drain.pop_front());
          if (m_drain.size() == 0) m_done = 1;
        end
        if (bus.in_valid) begin
          if (m_capturing) begin
            m_frame.push_back(bus.in_data);
            if (m_frame.size() == ADDR_COUNT) begin
              m_drain = m_frame;
              m_capturing = 0;
              m_acc_sum = '0;
              foreach (m_frame[i]) m_acc_sum += ACC_WIDTH'(m_frame[i]);
              m_acc_valid = 1;
            end
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
  end

  int ready_mode = 0;
  int ready_phase = 0;
  initial begin
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) bus.rd_ready = 1'b1;
      else begin
        bus.rd_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
        ready_phase++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input logic v, input product_t d);
    beat_addr.delete(); beat_data.delete(); done_seen = 0;
    frame_start = 1'b1; bus.in_valid = v; bus.in_data = d;
    tick();
    frame_start = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic cap_word(input product_t d, input int gap);
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin tick(); n++; end
    check("drain_completes", done_seen, 1);
  endtask

  logic [ACC_WIDTH-1:0] lit_acc;
  int ff_count;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("idle_no_valid", bus.rd_valid, 0);

    // Basic frame: k*3, ready held high.
    start_frame(1'b0, '0);
    for (int k = 0; k < 32; k++) cap_word(product_t'(k * 3), 0);
    check("latency_one_cycle", bus.rd_valid, 1);
    wait_done(100);
    check("basic_beats", beat_data.size(), 32);
    check("basic_addr31", beat_addr[31], 31);
    check("basic_data31", beat_data[31], 93);
    check("basic_data10", beat_data[10], 30);
    check("basic_drain_cycles", done_cyc - first_valid_cyc, 32);
`ifdef DCIM_COLLECTOR_ACCUM_EN
    lit_acc = 37'd1488;
`else
    lit_acc = '0;
`endif
    check("basic_acc_sum", acc_sum, lit_acc);

    // Backpressure 1,0,0,1.
    ready_mode = 1; ready_phase = 0;
    start_frame(1'b0, '0);
    for (int k = 0; k < 32; k++) cap_word(product_t'(k * 3), 0);
    wait_done(300);
    check("bp_beats", beat_data.size(), 32);
    check("bp_data31", beat_data[31], 93);
    check("bp_addr17", beat_addr[17], 17);

    // Gapped all-ones capture.
    ready_mode = 0;
    start_frame(1'b0, '0);
    for (int k = 0; k < 32; k++) cap_word(32'hFFFF_FFFF, 1);
    wait_done(100);
    ff_count = 0;
    foreach (beat_data[i]) if (beat_data[i] == 32'hFFFF_FFFF) ff_count++;
    check("gap_all_ones", ff_count, 32);
`ifdef DCIM_COLLECTOR_ACCUM_EN
    lit_acc = 37'h1F_FFFF_FFE0;
`else
    lit_acc = '0;
`endif
    check("gap_acc_sum", acc_sum, lit_acc);

    // Overflow during drain, held into IDLE, cleared by frame_start.
    ready_mode = 1; ready_phase = 0;
    start_frame(1'b0, '0);
    for (int k = 0; k < 32; k++) cap_word(product_t'(k + 40), 0);
    tick();
    cap_word(32'h1234, 2);
    wait_done(300);
    check("ovf_beats", beat_data.size(), 32);
    check("ovf_data5", beat_data[5], 45);
    tick();
    check("ovf_held", overflow, 1);

    // Restart after 10 captures.
    ready_mode = 0;
    start_frame(1'b0, '0);
    check("ovf_cleared", overflow, 0);
    for (int k = 0; k < 10; k++) cap_word(product_t'(500 + k), 0);
    start_frame(1'b0, '0);
    for (int k = 0; k < 32; k++) cap_word(product_t'(100 + k), 0);
    wait_done(100);
    check("restart_first", beat_data[0], 100);
    check("restart_last", beat_data[31], 131);

    // frame_start coincident with in_valid.
    start_frame(1'b1, 32'd7);
    for (int k = 1; k < 32; k++) cap_word(product_t'(k * 5), 0);
    wait_done(100);
    check("coincident_addr0", beat_addr[0], 0);
    check("coincident_data0", beat_data[0], 7);
    check("coincident_data1", beat_data[1], 5);

    // Async reset mid-drain, between edges.
    ready_mode = 1; ready_phase = 0;
    start_frame(1'b0, '0);
    for (int k = 0; k < 32; k++) cap_word(product_t'(k), 0);
    cap_word(32'h1234, 4);
    check("pre_reset_valid", bus.rd_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rd_valid", bus.rd_valid, 0);
    check("async_frame_done", frame_done, 0);
    check("async_overflow", overflow, 0);
    check("async_acc_valid", acc_valid, 0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("post_reset_idle", bus.rd_valid, 0);
    cap_word(32'h55, 2);
    check("post_reset_ovf", overflow, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
